// File: rtl/seq_pattern_fsm_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int PATTERN_LEN_MIN = 2;
    localparam int PATTERN_LEN_MAX = 16;

    // Bits needed to hold a fill level of 0..len inclusive.
    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear on clr or areset.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_fsm.sv
// Registered serial pattern detector with a one-cycle Moore match flag.
// Optional saturating match counter enabled by SEQ_PATTERN_MATCH_CNT_EN.
//
// state | meaning
// IDLE  | no bits collected (fill == 0)
// FILL  | partial history (0 < fill < PATTERN_LEN)
// ARMED | full history, every enabled bit is a match candidate
module seq_pattern_fsm
    import seq_pattern_pkg::*;
#(
    parameter int PATTERN_LEN = 4,
    parameter int OVERLAP     = 1,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   x,
    input  logic [PATTERN_LEN-1:0] pattern,
    output logic                   z,
    output logic [1:0]             state
`ifdef SEQ_PATTERN_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]       match_cnt
`endif
);

    localparam int FW = fill_width(PATTERN_LEN);
    localparam logic [FW-1:0] FILL_FULL = FW'(PATTERN_LEN);

    if ((PATTERN_LEN < PATTERN_LEN_MIN) || (PATTERN_LEN > PATTERN_LEN_MAX)) begin : g_len_chk
        $error("seq_pattern_fsm: PATTERN_LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_cnt_chk
        $error("seq_pattern_fsm: CNT_W must be at least 1");
    end

    logic [PATTERN_LEN-1:0] hist, hist_n, shifted;
    logic [FW-1:0]          fill, fill_n, fill_inc;
    logic                   z_n;
    logic                   match;
    state_t                 cur_state;

    // State register: history, fill level and the registered match flag.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hist <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else begin
            hist <= hist_n;
            fill <= fill_n;
            z    <= z_n;
        end
    end

    // Next-state: shift in on enabled edges, compare against the live pattern.
    always_comb begin
        hist_n   = hist;
        fill_n   = fill;
        z_n      = 1'b0;
        match    = 1'b0;
        shifted  = {hist[PATTERN_LEN-2:0], x};
        fill_inc = (fill == FILL_FULL) ? fill : fill + FW'(1);
        if (clr) begin
            hist_n = '0;
            fill_n = '0;
        end else if (en) begin
            match = (fill_inc == FILL_FULL) && (shifted == pattern);
            z_n   = match;
            if (match && (OVERLAP == 0)) begin
                hist_n = '0;
                fill_n = '0;
            end else begin
                hist_n = shifted;
                fill_n = fill_inc;
            end
        end
    end

    // State is a pure decode of the fill level, so it can never reach encoding 3.
    always_comb begin
        if (fill == '0) begin
            cur_state = IDLE;
        end else if (fill == FILL_FULL) begin
            cur_state = ARMED;
        end else begin
            cur_state = FILL;
        end
    end

    assign state = cur_state;

`ifdef SEQ_PATTERN_MATCH_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .areset (areset),
        .clr    (clr),
        .inc    (match),
        .cnt    (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_pattern_fsm.sv
module tb_seq_pattern_fsm;

    logic       clk;
    logic       areset;
    logic       clr;
    logic       en;
    logic       x;
    logic [3:0] pat;

    logic       z_o  [3];
    logic [1:0] st_o [3];
`ifdef SEQ_PATTERN_MATCH_CNT_EN
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [7:0] cnt_o [3];
    assign cnt_o[0] = cnt_a;
    assign cnt_o[1] = cnt_b;
    assign cnt_o[2] = {6'b0, cnt_c};
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // A: overlap, CNT_W=8   B: non-overlap, CNT_W=8   C: overlap, CNT_W=2
    seq_pattern_fsm #(.PATTERN_LEN(4), .OVERLAP(1), .CNT_W(8)) u_a (
        .clk(clk), .areset(areset), .clr(clr), .en(en), .x(x), .pattern(pat),
        .z(z_o[0]), .state(st_o[0])
`ifdef SEQ_PATTERN_MATCH_CNT_EN
        , .match_cnt(cnt_a)
`endif
    );
    seq_pattern_fsm #(.PATTERN_LEN(4), .OVERLAP(0), .CNT_W(8)) u_b (
        .clk(clk), .areset(areset), .clr(clr), .en(en), .x(x), .pattern(pat),
        .z(z_o[1]), .state(st_o[1])
`ifdef SEQ_PATTERN_MATCH_CNT_EN
        , .match_cnt(cnt_b)
`endif
    );
    seq_pattern_fsm #(.PATTERN_LEN(4), .OVERLAP(1), .CNT_W(2)) u_c (
        .clk(clk), .areset(areset), .clr(clr), .en(en), .x(x), .pattern(pat),
        .z(z_o[2]), .state(st_o[2])
`ifdef SEQ_PATTERN_MATCH_CNT_EN
        , .match_cnt(cnt_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  z;
        logic [5:0]  st;
        logic [23:0] cnt;
    } exp_t;

    exp_t q[$];

    logic [3:0] mh   [3];
    int         mf   [3];
    int         mc   [3];
    int         zc   [3];
    int         ovl  [3] = '{1, 0, 1};
    int         cmax [3] = '{255, 255, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mh[i] = '0; mf[i] = 0; mc[i] = 0;
        end
    endtask

    task automatic zc_reset();
        for (int i = 0; i < 3; i++) zc[i] = 0;
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic step(input logic e, input logic xv, input logic c);
        exp_t       ex;
        logic [3:0] hn;
        int         fn;
        logic       m;
        @(negedge clk);
        en = e; x = xv; clr = c;
        ex = '0;
        for (int i = 0; i < 3; i++) begin
            m = 1'b0;
            if (c) begin
                mh[i] = '0; mf[i] = 0; mc[i] = 0;
            end else if (e) begin
                hn = {mh[i][2:0], xv};
                fn = (mf[i] < 4) ? mf[i] + 1 : 4;
                m  = (fn == 4) && (hn == pat);
                if (m && ovl[i] == 0) begin
                    mh[i] = '0; mf[i] = 0;
                end else begin
                    mh[i] = hn; mf[i] = fn;
                end
                if (m && mc[i] < cmax[i]) mc[i]++;
            end
            ex.z[i]          = m;
            ex.st[i*2 +: 2]  = (mf[i] == 0) ? 2'd0 : (mf[i] == 4) ? 2'd2 : 2'd1;
            ex.cnt[i*8 +: 8] = 8'(mc[i]);
        end
        q.push_back(ex);
        @(posedge clk);
        #1;
        ex = q.pop_front();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("z[%0d]", i), 32'(z_o[i]), 32'(ex.z[i]));
            check($sformatf("state[%0d]", i), 32'(st_o[i]), 32'(ex.st[i*2 +: 2]));
`ifdef SEQ_PATTERN_MATCH_CNT_EN
            check($sformatf("match_cnt[%0d]", i), 32'(cnt_o[i]), 32'(ex.cnt[i*8 +: 8]));
`endif
            if (z_o[i] === 1'b1) zc[i]++;
        end
    endtask

    task automatic check_all_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s z[%0d]", tag, i), 32'(z_o[i]), 32'd0);
            check($sformatf("%s state[%0d]", tag, i), 32'(st_o[i]), 32'd0);
`ifdef SEQ_PATTERN_MATCH_CNT_EN
            check($sformatf("%s match_cnt[%0d]", tag, i), 32'(cnt_o[i]), 32'd0);
`endif
        end
    endtask

    initial begin
        areset = 1'b1; clr = 1'b0; en = 1'b0; x = 1'b0; pat = 4'b1011;
        model_reset();
        zc_reset();
        #23;
        check_all_reset("reset");
        @(negedge clk);
        areset = 1'b0;

        // Overlap vs non-overlap on 1,0,1,1,0,1,1.
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        check("t1 pulses A", 32'(zc[0]), 32'd2);
        check("t1 pulses B", 32'(zc[1]), 32'd1);
`ifdef SEQ_PATTERN_MATCH_CNT_EN
        check("t1 cnt A", 32'(cnt_a), 32'd2);
        check("t1 cnt B", 32'(cnt_b), 32'd1);
`endif

        // Enable gaps do not break a partial match.
        step(0, 0, 1);
        zc_reset();
        step(1, 1, 0); step(1, 0, 0);
        step(0, 1'($urandom_range(0, 1)), 0);
        step(0, 1'($urandom_range(0, 1)), 0);
        step(0, 1'($urandom_range(0, 1)), 0);
        step(1, 1, 0); step(1, 1, 0);
        check("t2 pulses A", 32'(zc[0]), 32'd1);
        check("t2 pulses B", 32'(zc[1]), 32'd1);

        // clr with en=1 drops the bit and returns to IDLE.
        step(0, 0, 1);
        step(1, 1, 0); step(1, 0, 0);
        step(1, 1, 1);
        check("t3 state after clr", 32'(st_o[0]), 32'd0);
        zc_reset();
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        check("t3 no early match", 32'(zc[0]), 32'd0);
        step(1, 1, 0);
        check("t3 pulses A", 32'(zc[0]), 32'd1);

        // All-ones pattern: back-to-back matches and counter saturation.
        step(0, 0, 1);
        pat = 4'b1111;
        zc_reset();
        for (int k = 0; k < 8; k++) step(1, 1, 0);
        check("t4 pulses C", 32'(zc[2]), 32'd5);
        check("t4 pulses B", 32'(zc[1]), 32'd2);
`ifdef SEQ_PATTERN_MATCH_CNT_EN
        check("t4 cnt C sat", 32'(cnt_c), 32'd3);
        check("t4 cnt A", 32'(cnt_a), 32'd5);
`endif

        // Asynchronous reset mid-cycle while ARMED with z high.
        step(0, 0, 1);
        pat = 4'b1011;
        step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
        check("t5 z high before reset", 32'(z_o[0]), 32'd1);
        check("t5 armed before reset", 32'(st_o[0]), 32'd2);
        #2;
        areset = 1'b1;
        #1;
        check_all_reset("async");
        model_reset();
        @(negedge clk);
        areset = 1'b0;
        step(1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
